// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receiver.
package ps2_pkg;

    localparam int unsigned FRAME_BITS         = 8;
    localparam int unsigned FILTER_LEN_DEFAULT = 8;
    localparam int unsigned TIMEOUT_DEFAULT    = 6400;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } ps2_state_e;

    // A frame is accepted when the stop bit is 1 and data plus parity has odd weight.
    function automatic logic frame_ok(logic [FRAME_BITS-1:0] byte_in, logic par, logic stop);
        return stop & (^{byte_in, par});
    endfunction

endpackage

// File: rtl/ps2_if.sv
// PS/2 pins plus received-byte outputs. The device side drives the pins,
// the receiver reads them and reports bytes.
interface ps2_if;
    import ps2_pkg::*;

    logic                  ps2_clk;
    logic                  ps2_data;
    logic [FRAME_BITS-1:0] data;
    logic                  valid;
    logic                  error;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  data,
        input  valid,
        input  error
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output data,
        output valid,
        output error
    );

endinterface

// File: rtl/ps2_sync_filter.sv
// Synchronises the raw PS/2 clock, debounces it with an all-ones/all-zeros
// filter and emits a registered one-cycle strobe on each filtered falling edge.
module ps2_sync_filter
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = FILTER_LEN_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk_i,
    output logic fall_o
);

    logic [1:0]            sync_q;
    logic [FILTER_LEN-1:0] taps_q;
    logic                  filt_q;
    logic                  filt_d;
    logic                  fall_q;

    // Filtered clock only changes once every tap agrees; otherwise it holds.
    always_comb begin
        filt_d = filt_q;
        if (&taps_q) begin
            filt_d = 1'b1;
        end else if (~|taps_q) begin
            filt_d = 1'b0;
        end
    end

    // Synchroniser, tap shift register, filtered level and fall strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b11;
            taps_q <= '1;
            filt_q <= 1'b1;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], ps2_clk_i};
            taps_q <= {taps_q[FILTER_LEN-2:0], sync_q[1]};
            filt_q <= filt_d;
            fall_q <= filt_q & ~filt_d;
        end
    end

    assign fall_o = fall_q;

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB first, odd
// parity, stop. Reports each frame as a one-cycle valid or error strobe.
module ps2_receiver
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = FILTER_LEN_DEFAULT,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT
) (
    input logic   clk,
    input logic   reset,
    ps2_if.slave  bus
);

    localparam int unsigned CntW = $clog2(FRAME_BITS);
    localparam int unsigned ToW  = $clog2(TIMEOUT + 1);

    logic                  fall;
    logic [1:0]            dsync_q;
    logic                  din;
    ps2_state_e            state_q, state_d;
    logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic                  par_q, par_d;
    logic [ToW-1:0]        to_cnt_q, to_cnt_d;
    logic [FRAME_BITS-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  error_q, error_d;

    ps2_sync_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk_i (bus.ps2_clk),
        .fall_o    (fall)
    );

    assign din = dsync_q[1];

    // Frame FSM: next state, shift/parity capture, timeout and result strobes.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        to_cnt_d  = to_cnt_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        error_d   = 1'b0;

        if (state_q != StIdle) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (fall && !din) begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                    to_cnt_d  = '0;
                end
            end
            StData: begin
                if (fall) begin
                    shreg_d   = {din, shreg_q[FRAME_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    to_cnt_d  = '0;
                    if (bit_cnt_q == CntW'(FRAME_BITS - 1)) begin
                        state_d = StParity;
                    end
                end
            end
            StParity: begin
                if (fall) begin
                    par_d    = din;
                    to_cnt_d = '0;
                    state_d  = StStop;
                end
            end
            StStop: begin
                if (fall) begin
                    to_cnt_d = '0;
                    state_d  = StIdle;
                    if (frame_ok(shreg_q, par_q, din)) begin
                        valid_d = 1'b1;
                        data_d  = shreg_q;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Clock stalled mid-frame: abandon the partial byte.
        if (state_q != StIdle && !fall && to_cnt_q == ToW'(TIMEOUT - 1)) begin
            state_d  = StIdle;
            to_cnt_d = '0;
            error_d  = 1'b1;
        end
    end

    // State registers and the plain data-pin synchroniser.
    always_ff @(posedge clk) begin
        if (reset) begin
            dsync_q   <= 2'b11;
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            to_cnt_q  <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            dsync_q   <= {dsync_q[0], bus.ps2_data};
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            to_cnt_q  <= to_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
        end
    end

    assign bus.data  = data_q;
    assign bus.valid = valid_q;
    assign bus.error = error_q;

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed and randomized frames against a frame-level model of the receiver.
module tb_ps2_receiver;

    localparam int FL   = 8;
    localparam int TO   = 500;
    localparam int HALF = 40;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;
    int   valid_cnt;
    int   error_cnt;
    int   both_cnt;
    int   valid_cyc;
    int   error_cyc;
    int   last_fall;
    logic [7:0] model_data;

    ps2_if bus ();

    ps2_receiver #(
        .FILTER_LEN (FL),
        .TIMEOUT    (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.valid) begin
                valid_cnt = valid_cnt + 1;
                valid_cyc = cyc;
            end
            if (bus.error) begin
                error_cnt = error_cnt + 1;
                error_cyc = cyc;
            end
            if (bus.valid && bus.error) both_cnt = both_cnt + 1;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input logic par,
                                               input logic stop);
        return {stop, par, b, 1'b0};
    endfunction

    // Drives nbits of a frame, bit i set while clock high, sampled on the fall.
    task automatic send(input logic [10:0] frame, input int nbits, input int glitch_after);
        for (int i = 0; i < nbits; i++) begin
            bus.ps2_data = frame[i];
            tick(HALF);
            bus.ps2_clk = 1'b0;
            last_fall   = cyc;
            tick(HALF);
            bus.ps2_clk = 1'b1;
            if (i == glitch_after) begin
                tick(20);
                bus.ps2_clk = 1'b0;
                tick(4);
                bus.ps2_clk = 1'b1;
            end
        end
        bus.ps2_data = 1'b1;
    endtask

    // Sends a full frame and compares against the frame-level rule.
    task automatic full_frame(input string tag, input logic [7:0] b, input logic par,
                              input logic stop, input int glitch_after);
        int  v0, e0;
        logic ok;
        v0 = valid_cnt;
        e0 = error_cnt;
        ok = stop && (($countones(b) + int'(par)) % 2 == 1);
        send(make_frame(b, par, stop), 11, glitch_after);
        tick(FL + 20);
        if (ok) model_data = b;
        check({tag, "_valid"}, valid_cnt - v0, ok ? 1 : 0);
        check({tag, "_error"}, error_cnt - e0, ok ? 0 : 1);
        check({tag, "_data"}, bus.data, model_data);
        if (ok) check({tag, "_latency"}, valid_cyc - last_fall, FL + 4);
    endtask

    initial begin
        int v0, e0, lat, waited;
        logic [7:0] b;
        int kind;

        cyc = 0; checks = 0; errors = 0;
        valid_cnt = 0; error_cnt = 0; both_cnt = 0;
        valid_cyc = 0; error_cyc = 0; last_fall = 0;
        model_data = 8'h00;
        bus.ps2_clk = 1'b1;
        bus.ps2_data = 1'b1;
        reset = 1'b1;
        tick(4);
        check("rst_data", bus.data, 8'h00);
        check("rst_valid", bus.valid, 1'b0);
        check("rst_error", bus.error, 1'b0);
        reset = 1'b0;
        tick(FL + 10);
        check("idle_no_pulse", valid_cnt + error_cnt, 0);

        full_frame("clean08", 8'h08, 1'b0, 1'b1, -1);
        full_frame("badpar_aa", 8'hAA, 1'b0, 1'b1, -1);
        full_frame("badstop_55", 8'h55, 1'b1, 1'b0, -1);

        // Stalled clock after start plus four data bits.
        v0 = valid_cnt;
        e0 = error_cnt;
        send(make_frame(8'h0F, 1'b1, 1'b1), 5, -1);
        waited = 0;
        while (error_cnt == e0 && waited < TO + FL + 100) begin
            tick(1);
            waited++;
        end
        lat = error_cyc - last_fall;
        check("to_error", error_cnt - e0, 1);
        check("to_valid", valid_cnt - v0, 0);
        check("to_latency_in_window", (lat >= TO + FL + 2 && lat <= TO + FL + 6), 1'b1);
        check("to_data_kept", bus.data, model_data);
        tick(20);
        full_frame("after_to_10", 8'h10, 1'b0, 1'b1, -1);

        full_frame("glitch_c3", 8'hC3, 1'b1, 1'b1, 3);

        // Reset in the middle of a frame.
        v0 = valid_cnt;
        e0 = error_cnt;
        send(make_frame(8'hFF, 1'b1, 1'b1), 7, -1);
        tick(10);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        model_data = 8'h00;
        tick(FL + 20);
        check("midrst_valid", valid_cnt - v0, 0);
        check("midrst_error", error_cnt - e0, 0);
        check("midrst_data", bus.data, 8'h00);
        full_frame("after_rst_3c", 8'h3C, 1'b1, 1'b1, -1);

        // Random frames: good, bad parity, or bad stop bit.
        for (int n = 0; n < 10; n++) begin
            b = 8'($urandom);
            kind = int'($urandom_range(0, 2));
            case (kind)
                0: full_frame("rand_good", b, ~^b, 1'b1, -1);
                1: full_frame("rand_badpar", b, ^b, 1'b1, -1);
                default: full_frame("rand_badstop", b, ~^b, 1'b0, -1);
            endcase
        end

        check("never_both", both_cnt, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
